// File: rtl/cpu_axi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_axi_pkg
// Brief    : Shared AXI IDs, AR FSM encoding and tie-off constants for the
//            CPU-side AXI bridge.
// Revision : 1.0
// ============================================================================
package cpu_axi_pkg;

    localparam logic [3:0] AXI_INST_ID  = 4'd0;
    localparam logic [3:0] AXI_DATA_ID  = 4'd1;

    localparam int         AR_STATE_W   = 1;
    localparam logic [AR_STATE_W-1:0] AR_IDLE = 1'b0;
    localparam logic [AR_STATE_W-1:0] AR_SEND = 1'b1;

    localparam logic [1:0] ARBURST_INCR = 2'b01;
    localparam logic [7:0] ARLEN_SINGLE = 8'd0;

endpackage : cpu_axi_pkg
`default_nettype wire

// File: rtl/axi_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : axi_rd_arbiter
// Brief    : Shares one AXI read channel between instruction and data ports,
//            data first, one outstanding read each, RAW hold-off vs writes.
// Revision : 1.0
// ============================================================================
module axi_rd_arbiter
    import cpu_axi_pkg::*;
#(
    parameter logic [3:0] INST_ID = AXI_INST_ID,
    parameter logic [3:0] DATA_ID = AXI_DATA_ID
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_req,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    input  logic        wr_busy,
    input  logic [31:0] wr_addr,

    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [2:0]  arsize,
    output logic        arvalid,
    input  logic        arready,

    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic        rvalid,
    output logic        rready
);

    logic [AR_STATE_W-1:0] r_state;
    logic [AR_STATE_W-1:0] w_state_nxt;
    logic                  r_inst_pend;
    logic                  r_data_pend;

    logic w_data_hazard;
    logic w_data_elig;
    logic w_inst_elig;
    logic w_r_inst;
    logic w_r_data;
    logic w_unused_wr_lsb;

    // Word-granular compare: a pending write to the same word must land first.
    assign w_data_hazard   = wr_busy && (wr_addr[31:2] == data_addr[31:2]);
    assign w_data_elig     = data_req && !r_data_pend && !w_data_hazard;
    assign w_inst_elig     = inst_req && !r_inst_pend;
    assign w_r_inst        = rvalid && rready && (rid == INST_ID);
    assign w_r_data        = rvalid && rready && (rid == DATA_ID);
    assign w_unused_wr_lsb = ^wr_addr[1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= AR_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            AR_IDLE: if (w_data_elig || w_inst_elig) w_state_nxt = AR_SEND;
            AR_SEND: if (arready)                    w_state_nxt = AR_IDLE;
            default:                                 w_state_nxt = AR_IDLE;
        endcase
    end

    always_comb begin
        data_addr_ok = !reset && (r_state == AR_IDLE) && w_data_elig;
        inst_addr_ok = !reset && (r_state == AR_IDLE) && w_inst_elig && !w_data_elig;
        arvalid      = (r_state == AR_SEND);
        rready       = !reset;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            arid   <= 4'd0;
            araddr <= 32'd0;
            arsize <= 3'd0;
        end else if (data_addr_ok) begin
            arid   <= DATA_ID;
            araddr <= data_addr;
            arsize <= {1'b0, data_size};
        end else if (inst_addr_ok) begin
            arid   <= INST_ID;
            araddr <= inst_addr;
            arsize <= {1'b0, inst_size};
        end
    end

    // A returning beat clears pend on the same edge; a new grant needs the next cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_inst_pend <= 1'b0;
            r_data_pend <= 1'b0;
        end else begin
            if (w_r_inst)     r_inst_pend <= 1'b0;
            if (w_r_data)     r_data_pend <= 1'b0;
            if (inst_addr_ok) r_inst_pend <= 1'b1;
            if (data_addr_ok) r_data_pend <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            inst_data_ok <= 1'b0;
            data_data_ok <= 1'b0;
            inst_rdata   <= 32'd0;
            data_rdata   <= 32'd0;
        end else begin
            inst_data_ok <= w_r_inst;
            data_data_ok <= w_r_data;
            if (w_r_inst) inst_rdata <= rdata;
            if (w_r_data) data_rdata <= rdata;
        end
    end

endmodule : axi_rd_arbiter
`default_nettype wire

// File: tb/tb_axi_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_rd_arbiter
// Brief    : Directed scenarios plus random traffic against a transaction-level
//            model of the read arbiter and a simple out-of-order AXI slave.
// Revision : 1.0
// ============================================================================
module tb_axi_rd_arbiter;
    import cpu_axi_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req, data_req, wr_busy, arready, rvalid;
    logic [1:0]  inst_size, data_size;
    logic [31:0] inst_addr, data_addr, wr_addr, rdata;
    logic [3:0]  rid;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata, araddr;
    logic [3:0]  arid;
    logic [2:0]  arsize;
    logic        arvalid, rready;

    always #5 clk = ~clk;

    axi_rd_arbiter #(.INST_ID(AXI_INST_ID), .DATA_ID(AXI_DATA_ID)) u_dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_size(inst_size), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_size(data_size), .data_addr(data_addr),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .wr_busy(wr_busy), .wr_addr(wr_addr),
        .arid(arid), .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rvalid(rvalid), .rready(rready)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference model: address channel occupied or free, one pending read per port.
    bit          m_known = 0;
    bit          m_ar_busy, m_ipend, m_dpend, m_iok, m_dok;
    logic [3:0]  m_arid;
    logic [31:0] m_araddr, m_irdata, m_drdata;
    logic [2:0]  m_arsize;
    logic [3:0]  sq_id[$];
    logic [31:0] sq_data[$];
    int          slave_pick = -1;

    task automatic model_clear();
        m_ar_busy = 0; m_ipend = 0; m_dpend = 0; m_iok = 0; m_dok = 0;
        m_arid = '0; m_araddr = '0; m_arsize = '0; m_irdata = '0; m_drdata = '0;
        sq_id.delete(); sq_data.delete();
    endtask

    task automatic set_idle();
        reset = 0; inst_req = 0; data_req = 0; wr_busy = 0; arready = 0; rvalid = 0;
        inst_size = 2'd2; data_size = 2'd2; inst_addr = '0; data_addr = '0;
        wr_addr = '0; rdata = '0; rid = '0; slave_pick = -1;
    endtask

    // Inputs are set at posedge+1; check mid-cycle, advance the model, return at posedge+1.
    task automatic cycle();
        bit hz, de, ie, g_d, g_i;
        #2;
        hz  = wr_busy && ((wr_addr >> 2) == (data_addr >> 2));
        de  = data_req && !m_dpend && !hz;
        ie  = inst_req && !m_ipend;
        g_d = !reset && !m_ar_busy && de;
        g_i = !reset && !m_ar_busy && ie && !de;
        if (m_known) begin
            chk("data_addr_ok", data_addr_ok, g_d);
            chk("inst_addr_ok", inst_addr_ok, g_i);
            chk("arvalid", arvalid, m_ar_busy);
            chk("rready", rready, !reset);
            if (m_ar_busy) begin
                chk("arid", arid, m_arid);
                chk("araddr", araddr, m_araddr);
                chk("arsize", arsize, m_arsize);
            end
            chk("inst_data_ok", inst_data_ok, m_iok);
            chk("data_data_ok", data_data_ok, m_dok);
            chk("inst_rdata", inst_rdata, m_irdata);
            chk("data_rdata", data_rdata, m_drdata);
        end
        if (reset) begin
            model_clear();
            m_known = 1;
        end else begin
            if (m_ar_busy && arready) begin
                sq_id.push_back(m_arid);
                sq_data.push_back($urandom);
                m_ar_busy = 0;
            end
            m_iok = 0;
            m_dok = 0;
            if (rvalid) begin
                if (rid == AXI_INST_ID) begin
                    m_iok = 1; m_irdata = rdata; m_ipend = 0;
                end else if (rid == AXI_DATA_ID) begin
                    m_dok = 1; m_drdata = rdata; m_dpend = 0;
                end
                if (slave_pick >= 0) begin
                    sq_id.delete(slave_pick);
                    sq_data.delete(slave_pick);
                end
            end
            if (g_d) begin
                m_ar_busy = 1; m_arid = AXI_DATA_ID; m_araddr = data_addr;
                m_arsize = {1'b0, data_size}; m_dpend = 1;
            end else if (g_i) begin
                m_ar_busy = 1; m_arid = AXI_INST_ID; m_araddr = inst_addr;
                m_arsize = {1'b0, inst_size}; m_ipend = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive_random();
        reset     = ($urandom % 250) == 0;
        inst_req  = ($urandom % 4) != 0;
        data_req  = ($urandom % 4) != 0;
        inst_addr = $urandom;
        inst_size = 2'($urandom_range(0, 2));
        data_size = 2'($urandom_range(0, 2));
        wr_busy   = ($urandom % 2) != 0;
        wr_addr   = $urandom;
        data_addr = (($urandom % 2) != 0) ? (wr_addr ^ 32'($urandom % 8)) : $urandom;
        arready   = ($urandom % 3) != 0;
        slave_pick = -1;
        rvalid    = 0;
        rid       = '0;
        rdata     = $urandom;
        if (sq_id.size() > 0 && ($urandom % 2) != 0) begin
            slave_pick = int'($urandom % 32'(sq_id.size()));
            rvalid = 1;
            rid    = sq_id[slave_pick];
            rdata  = sq_data[slave_pick];
        end else if (($urandom % 16) == 0) begin
            rvalid = 1;
            rid    = 4'(2 + ($urandom % 14));
        end
    endtask

    initial begin
        set_idle();
        model_clear();
        reset = 1;
        @(posedge clk); #1;
        cycle();
        cycle();
        reset = 0;
        chk("rst_arvalid", arvalid, 0);
        chk("rst_arid", arid, 0);
        chk("rst_araddr", araddr, 0);
        chk("rst_arsize", arsize, 0);
        chk("rst_inst_rdata", inst_rdata, 0);
        chk("rst_data_rdata", data_rdata, 0);

        // Instruction read alone, minimum latency
        inst_req = 1; inst_addr = 32'h1c000000; arready = 1;
        cycle();
        inst_req = 0;
        chk("io_arvalid", arvalid, 1);
        chk("io_arid", arid, AXI_INST_ID);
        chk("io_araddr", araddr, 32'h1c000000);
        cycle();
        rvalid = 1; rid = AXI_INST_ID; rdata = 32'h02800c0c;
        cycle();
        rvalid = 0;
        chk("io_data_ok", inst_data_ok, 1);
        chk("io_rdata", inst_rdata, 32'h02800c0c);
        cycle();

        // Both requesting: data first, inst two cycles later; inst returns first
        inst_req = 1; inst_addr = 32'h1c000040; data_req = 1; data_addr = 32'h80001000;
        cycle();
        data_req = 0;
        chk("sim_arid_data", arid, AXI_DATA_ID);
        chk("sim_araddr_data", araddr, 32'h80001000);
        cycle();
        cycle();
        inst_req = 0;
        chk("sim_arid_inst", arid, AXI_INST_ID);
        cycle();
        rvalid = 1; rid = AXI_INST_ID; rdata = 32'haaaa0000;
        cycle();
        rid = AXI_DATA_ID; rdata = 32'hbbbb1111;
        chk("ooo_inst_ok", inst_data_ok, 1);
        chk("ooo_data_not_yet", data_data_ok, 0);
        cycle();
        rvalid = 0;
        chk("ooo_data_ok", data_data_ok, 1);
        chk("ooo_data_rdata", data_rdata, 32'hbbbb1111);
        chk("ooo_inst_rdata", inst_rdata, 32'haaaa0000);
        cycle();

        // Read-after-write hold-off, then address backpressure
        wr_busy = 1; wr_addr = 32'h80001004; data_req = 1; data_addr = 32'h80001006; arready = 0;
        repeat (3) cycle();
        wr_busy = 0;
        cycle();
        data_req = 0; inst_req = 1; inst_addr = 32'h1c000100;
        repeat (5) begin
            chk("bp_arvalid", arvalid, 1);
            chk("bp_araddr", araddr, 32'h80001006);
            cycle();
        end
        arready = 1;
        cycle();
        cycle();
        inst_req = 0;
        cycle();
        rvalid = 1; rid = AXI_DATA_ID; rdata = 32'h12345678;
        cycle();
        rid = AXI_INST_ID; rdata = 32'h9abcdef0;
        cycle();
        rvalid = 0;
        wr_busy = 1; wr_addr = 32'h80001004; data_req = 1; data_addr = 32'h80001008;
        cycle();
        data_req = 0; wr_busy = 0;
        chk("raw_diff_word_arid", arid, AXI_DATA_ID);
        chk("raw_diff_word_araddr", araddr, 32'h80001008);
        cycle();
        rvalid = 1; rid = AXI_DATA_ID; rdata = 32'h0badf00d;
        cycle();
        rvalid = 0;

        // Reset while an inst AR is stalled
        inst_req = 1; inst_addr = 32'h1c000200; arready = 0;
        cycle();
        inst_req = 0;
        cycle();
        reset = 1;
        cycle();
        reset = 0;
        chk("rmf_arvalid", arvalid, 0);
        chk("rmf_inst_ok", inst_data_ok, 0);
        inst_req = 1;
        cycle();
        inst_req = 0; arready = 1;
        chk("rmf_regrant", arvalid, 1);
        cycle();

        // Random traffic with an out-of-order slave
        repeat (3000) begin
            drive_random();
            cycle();
        end

        set_idle();
        cycle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_axi_rd_arbiter
`default_nettype wire
